// File: rtl/zone_scheduler_pkg.sv
// Shared state encodings and constants for the irrigation zone scheduler.
package zone_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_WATER  = 2'd2,
        ST_SETTLE = 2'd3
    } state_e;

    // Demux selector value that addresses no valve; zone i is selected by i+1.
    localparam logic [2:0] SEL_NONE  = 3'b000;
    localparam int         NUM_ZONES = 7;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clk divider: one-cycle tick every TICK_DIV cycles, restartable.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Tick is combinational from the count so the owner sees it in the same
    // cycle the count sits at its terminal value.
    assign tick = (cnt_q == LAST);

    // Next count: wrap at TICK_DIV-1, restart from 0 when the owner clears.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/zone_scheduler.sv
// One-zone-at-a-time valve sequencer driving a 1x7 active-low demux.
// Round-robin grant, timed watering window, settle gap; all outputs registered.
module zone_scheduler
    import zone_scheduler_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int WATER_TIME  = 10,
    parameter int SETTLE_TIME = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       water_ok,
    input  logic [6:0] req,
    output logic [2:0] sel,
    output logic       demux_in,
    output logic       busy,
    output logic [2:0] cur_zone,
    output logic       zone_done
);

    localparam int            MAX_T       = (WATER_TIME > SETTLE_TIME) ? WATER_TIME : SETTLE_TIME;
    localparam int            TW          = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam logic [TW-1:0] WATER_LAST  = TW'(WATER_TIME - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_TIME - 1);

    // Round-robin search: first requesting zone after 'last', wrapping back to it.
    function automatic logic [2:0] rr_pick(input logic [2:0] last, input logic [6:0] r);
        logic [2:0] idx;
        logic [2:0] win;
        logic       found;
        win   = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_ZONES; k++) begin
            idx = 3'((int'(last) + k) % NUM_ZONES);
            if (!found && r[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    state_e        state_q, state_d;
    logic [2:0]    sel_q, sel_d;
    logic          demux_in_q, demux_in_d;
    logic          busy_q, busy_d;
    logic [2:0]    cur_zone_q, cur_zone_d;
    logic          zone_done_q, zone_done_d;
    logic [2:0]    last_q, last_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [2:0]    win;
    logic          clear;
    logic          tick;
    logic          run_ok;

    assign run_ok = enable && water_ok;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .tick  (tick)
    );

    // Next-state and registered-output computation. sel only moves on the
    // IDLE->SELECT and SETTLE->IDLE edges, both of which follow a cycle with
    // demux_in already high, so the demux never sees a selector change while open.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cur_zone_d  = cur_zone_q;
        last_d      = last_q;
        zone_done_d = 1'b0;
        tcnt_d      = tick ? tcnt_q + TW'(1) : tcnt_q;
        win         = rr_pick(last_q, req);

        case (state_q)
            ST_IDLE: begin
                if (run_ok && (|req)) begin
                    state_d    = ST_SELECT;
                    sel_d      = win + 3'd1;
                    cur_zone_d = win;
                    last_d     = win;
                end
            end
            ST_SELECT: begin
                state_d = ST_WATER;
            end
            ST_WATER: begin
                // Abort takes priority over a coincident expiry: no completion pulse.
                if (!run_ok) begin
                    state_d = ST_SETTLE;
                end else if (tick && (tcnt_q == WATER_LAST)) begin
                    state_d     = ST_SETTLE;
                    zone_done_d = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (tick && (tcnt_q == SETTLE_LAST)) begin
                    state_d = ST_IDLE;
                    sel_d   = SEL_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = SEL_NONE;
            end
        endcase

        // Timing restarts on every state entry.
        clear = (state_d != state_q);
        if (clear) begin
            tcnt_d = '0;
        end

        demux_in_d = (state_d != ST_WATER);
        busy_d     = (state_d != ST_IDLE);
    end

    // State and output registers; reset closes all valves immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= SEL_NONE;
            demux_in_q  <= 1'b1;
            busy_q      <= 1'b0;
            cur_zone_q  <= 3'd0;
            zone_done_q <= 1'b0;
            last_q      <= 3'd6;
            tcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            demux_in_q  <= demux_in_d;
            busy_q      <= busy_d;
            cur_zone_q  <= cur_zone_d;
            zone_done_q <= zone_done_d;
            last_q      <= last_d;
            tcnt_q      <= tcnt_d;
        end
    end

    assign sel       = sel_q;
    assign demux_in  = demux_in_q;
    assign busy      = busy_q;
    assign cur_zone  = cur_zone_q;
    assign zone_done = zone_done_q;

endmodule

// File: tb/tb_zone_scheduler.sv
// Directed bench for zone_scheduler with TICK_DIV=4, WATER_TIME=3, SETTLE_TIME=2.
module tb_zone_scheduler;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       water_ok;
    logic [6:0] req;
    logic [2:0] sel;
    logic       demux_in;
    logic       busy;
    logic [2:0] cur_zone;
    logic       zone_done;

    int vectors = 0;
    int errors  = 0;

    zone_scheduler #(
        .TICK_DIV    (4),
        .WATER_TIME  (3),
        .SETTLE_TIME (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .water_ok  (water_ok),
        .req       (req),
        .sel       (sel),
        .demux_in  (demux_in),
        .busy      (busy),
        .cur_zone  (cur_zone),
        .zone_done (zone_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Settle window: 8 cycles with valves closed and sel held, then IDLE.
    task automatic settle(input int z, input logic done);
        step();
        chk("settle1_dmx", demux_in, 1);
        chk("settle1_done", zone_done, done);
        chk("settle1_sel", sel, z + 1);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("settle_dmx", demux_in, 1);
            chk("settle_done", zone_done, 0);
            chk("settle_sel", sel, z + 1);
            chk("settle_busy", busy, 1);
        end
        step();
        chk("idle_sel", sel, 0);
        chk("idle_busy", busy, 0);
        chk("idle_dmx", demux_in, 1);
    endtask

    task automatic select_chk(input int z);
        step();
        chk("select_sel", sel, z + 1);
        chk("select_zone", cur_zone, z);
        chk("select_dmx", demux_in, 1);
        chk("select_busy", busy, 1);
    endtask

    // Full grant: SELECT, 12 open cycles, settle with completion pulse.
    task automatic grant(input int z);
        select_chk(z);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("water_dmx", demux_in, 0);
            chk("water_sel", sel, z + 1);
        end
        settle(z, 1'b1);
    endtask

    // Glitch watch: sel may only move after a cycle with demux_in high.
    logic [2:0] prev_sel;
    logic       prev_dmx;
    logic       prev_rst;
    always @(negedge clk) begin
        if (rst_n && prev_rst) begin
            vectors++;
            assert (!((sel !== prev_sel) && (prev_dmx === 1'b0))) else begin
                errors++;
                $error("FAIL glitch: sel %0h -> %0h while demux_in was 0", prev_sel, sel);
            end
        end
        prev_sel <= sel;
        prev_dmx <= demux_in;
        prev_rst <= rst_n;
    end

    initial begin
        rst_n    = 1'b1;
        enable   = 1'b1;
        water_ok = 1'b1;
        req      = 7'd0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_sel", sel, 0);
        chk("rst_dmx", demux_in, 1);
        chk("rst_busy", busy, 0);
        chk("rst_zone", cur_zone, 0);
        chk("rst_done", zone_done, 0);
        step();
        step();
        rst_n = 1'b1;

        // Single request on zone 2.
        req = 7'b0000100;
        grant(2);

        // All zones requesting, starting from a fresh pointer.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req = 7'h7F;
        for (int g = 0; g < 8; g++) begin
            grant(g % 7);
        end

        // Zone 4 aborted on its 5th open cycle by low tank.
        req = 7'b0010000;
        select_chk(4);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("abort_water_dmx", demux_in, 0);
        end
        water_ok = 1'b0;
        settle(4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("noflow_busy", busy, 0);
            chk("noflow_sel", sel, 0);
        end

        // Disabled: requests ignored.
        enable   = 1'b0;
        water_ok = 1'b1;
        req      = 7'h7F;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("dis_busy", busy, 0);
            chk("dis_sel", sel, 0);
            chk("dis_dmx", demux_in, 1);
        end

        // Reset mid-water on zone 5 closes the valve asynchronously.
        req    = 7'b0100000;
        enable = 1'b1;
        select_chk(5);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("prerst_dmx", demux_in, 0);
        end
        #3 rst_n = 1'b0;
        #1;
        chk("async_dmx", demux_in, 1);
        chk("async_sel", sel, 0);
        chk("async_busy", busy, 0);
        step();
        step();
        rst_n = 1'b1;
        grant(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
